// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : widths and PC-select encodings shared across the CPU core  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int PC_WIDTH   = 12;
  localparam int DATA_WIDTH = 8;
  localparam int INST_WIDTH = 19;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_REL = 2'b01,
    PC_ABS = 2'b10,
    PC_RET = 2'b11
  } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/return_stack_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | return_stack_if : CALL/RET handshake between datapath and stack      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface return_stack_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] stack_in;
  logic             clear_err;
  logic [WIDTH-1:0] stack_out;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, stack_in, clear_err,
    input  stack_out, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, stack_in, clear_err,
    output stack_out, empty, full, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | return_stack : bounded return-address stack with sticky error flags  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module return_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = 8,
  parameter int WRAP  = 0,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  wire          clk,
  input  wire          reset,
  return_stack_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam bit c_wrap = (WRAP != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty, w_full;
  logic w_replace, w_advance, w_retreat;
  logic w_ovf_set, w_unf_set;
  logic [PW-1:0] w_top_inc;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_depth);
  assign w_top_inc = r_top + PW'(1);

  // A push+pop on an empty stack degenerates to a plain push.
  assign w_replace = bus.push && bus.pop && !w_empty;
  assign w_advance = bus.push && !w_replace && (!w_full || c_wrap);
  assign w_retreat = bus.pop && !bus.push && !w_empty;
  assign w_ovf_set = bus.push && !bus.pop && w_full;
  assign w_unf_set = bus.pop && !bus.push && w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_top       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_advance) begin
        r_top <= w_top_inc;
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_retreat) begin
        r_top   <= r_top - PW'(1);
        r_count <= r_count - CW'(1);
      end
      // Setting a flag wins over a clear in the same cycle.
      r_overflow  <= w_ovf_set || (r_overflow  && !bus.clear_err);
      r_underflow <= w_unf_set || (r_underflow && !bus.clear_err);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_replace)      r_mem[r_top]     <= bus.stack_in;
      else if (w_advance) r_mem[w_top_inc] <= bus.stack_in;
    end
  end

  assign bus.stack_out = w_empty ? '0 : r_mem[r_top];
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_return_stack : drop-policy and wrap-policy stacks vs queue models |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_return_stack;
  localparam int W = 12;
  localparam int D = 8;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  return_stack_if #(.WIDTH(W), .DEPTH(D)) ifa ();
  return_stack_if #(.WIDTH(W), .DEPTH(D)) ifb ();

  return_stack #(.WIDTH(W), .DEPTH(D), .WRAP(0)) dut_drop (.clk(clk), .reset(reset), .bus(ifa));
  return_stack #(.WIDTH(W), .DEPTH(D), .WRAP(1)) dut_wrap (.clk(clk), .reset(reset), .bus(ifb));

  // Reference: index 0 = drop policy, 1 = wrap policy; queue back is top of stack.
  logic [W-1:0] mq [2][$];
  logic         movf [2];
  logic         munf [2];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mtop(input int w);
    return (mq[w].size() == 0) ? 32'd0 : 32'(mq[w][mq[w].size()-1]);
  endfunction

  task automatic model_step(input logic p, input logic o, input logic [W-1:0] d,
                            input logic c, input logic r);
    for (int w = 0; w < 2; w++) begin
      logic so, su;
      so = 1'b0;
      su = 1'b0;
      if (r) begin
        mq[w].delete();
        movf[w] = 1'b0;
        munf[w] = 1'b0;
      end else begin
        if (p && o) begin
          if (mq[w].size() > 0) mq[w][mq[w].size()-1] = d;
          else mq[w].push_back(d);
        end else if (p) begin
          if (mq[w].size() < D) mq[w].push_back(d);
          else begin
            so = 1'b1;
            if (w == 1) begin
              void'(mq[w].pop_front());
              mq[w].push_back(d);
            end
          end
        end else if (o) begin
          if (mq[w].size() > 0) void'(mq[w].pop_back());
          else su = 1'b1;
        end
        movf[w] = so | (movf[w] & ~c);
        munf[w] = su | (munf[w] & ~c);
      end
    end
  endtask

  task automatic check_all();
    check("drop.count", 32'(ifa.count), 32'(mq[0].size()));
    check("drop.empty", 32'(ifa.empty), 32'(mq[0].size() == 0));
    check("drop.full",  32'(ifa.full),  32'(mq[0].size() == D));
    check("drop.out",   32'(ifa.stack_out), mtop(0));
    check("drop.ovf",   32'(ifa.overflow),  32'(movf[0]));
    check("drop.unf",   32'(ifa.underflow), 32'(munf[0]));
    check("wrap.count", 32'(ifb.count), 32'(mq[1].size()));
    check("wrap.empty", 32'(ifb.empty), 32'(mq[1].size() == 0));
    check("wrap.full",  32'(ifb.full),  32'(mq[1].size() == D));
    check("wrap.out",   32'(ifb.stack_out), mtop(1));
    check("wrap.ovf",   32'(ifb.overflow),  32'(movf[1]));
    check("wrap.unf",   32'(ifb.underflow), 32'(munf[1]));
  endtask

  task automatic step(input logic p, input logic o, input logic [W-1:0] d,
                      input logic c, input logic r);
    ifa.push = p; ifa.pop = o; ifa.stack_in = d; ifa.clear_err = c;
    ifb.push = p; ifb.pop = o; ifb.stack_in = d; ifb.clear_err = c;
    reset = r;
    @(posedge clk);
    model_step(p, o, d, c, r);
    #1;
    check_all();
  endtask

  initial begin
    movf[0] = 1'b0; movf[1] = 1'b0;
    munf[0] = 1'b0; munf[1] = 1'b0;
    ifa.push = 1'b0; ifa.pop = 1'b0; ifa.stack_in = '0; ifa.clear_err = 1'b0;
    ifb.push = 1'b0; ifb.pop = 1'b0; ifb.stack_in = '0; ifb.clear_err = 1'b0;

    // Reset then idle
    step(0, 0, '0, 0, 1);
    check("rst.count", 32'(ifa.count), 0);
    check("rst.empty", 32'(ifa.empty), 1);
    check("rst.out",   32'(ifa.stack_out), 0);
    step(0, 0, '0, 0, 0);

    // LIFO order, stack_out sampled before each pop
    step(1, 0, 12'h101, 0, 0);
    step(1, 0, 12'h202, 0, 0);
    step(1, 0, 12'h303, 0, 0);
    check("lifo.0", 32'(ifa.stack_out), 32'h303);
    step(0, 1, '0, 0, 0);
    check("lifo.1", 32'(ifa.stack_out), 32'h202);
    step(0, 1, '0, 0, 0);
    check("lifo.2", 32'(ifa.stack_out), 32'h101);
    step(0, 1, '0, 0, 0);
    check("lifo.empty", 32'(ifa.empty), 1);

    // Fill to DEPTH, then one more push under both policies
    for (int i = 1; i <= 8; i++) step(1, 0, 12'(i), 0, 0);
    check("fill.full", 32'(ifa.full), 1);
    step(1, 0, 12'd9, 0, 0);
    check("ovf.drop.flag", 32'(ifa.overflow), 1);
    check("ovf.drop.count", 32'(ifa.count), 8);
    check("ovf.drop.out", 32'(ifa.stack_out), 8);
    check("ovf.wrap.out", 32'(ifb.stack_out), 9);
    for (int i = 0; i < 8; i++) begin
      check("drain.drop", 32'(ifa.stack_out), 32'(8 - i));
      check("drain.wrap", 32'(ifb.stack_out), 32'(9 - i));
      step(0, 1, '0, 0, 0);
    end
    check("drain.wrap.empty", 32'(ifb.empty), 1);

    // Underflow and clear
    step(0, 0, '0, 1, 0);
    step(0, 1, '0, 0, 0);
    check("unf.set", 32'(ifa.underflow), 1);
    step(0, 0, '0, 1, 0);
    check("unf.clr", 32'(ifa.underflow), 0);
    step(0, 1, '0, 1, 0);
    check("unf.setwins", 32'(ifa.underflow), 1);
    step(0, 0, '0, 1, 0);

    // Simultaneous push and pop
    step(1, 0, 12'hABC, 0, 0);
    step(1, 1, 12'h555, 0, 0);
    check("tail.count", 32'(ifa.count), 1);
    check("tail.out", 32'(ifa.stack_out), 32'h555);
    step(0, 1, '0, 0, 0);
    step(1, 1, 12'h777, 0, 0);
    check("pp.empty.out", 32'(ifa.stack_out), 32'h777);
    check("pp.empty.unf", 32'(ifa.underflow), 0);
    step(1, 0, 12'h111, 0, 1);
    check("rst.push.count", 32'(ifa.count), 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic p, o, c, r;
      logic [W-1:0] d;
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 79) == 0);
      d = W'($urandom);
      step(p, o, d, c, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
